// File: rtl/rg_weighted_sampler.sv
// Categorical sampler: draws num_samples symbols from NUM_SYM integer weights
// using a seedable 32-bit Galois LFSR, streamed out over valid/ready.
module rg_weighted_sampler #(
  parameter int unsigned NUM_SYM = 4,
  parameter int unsigned PROB_W  = 10,
  parameter int unsigned CNT_W   = 16,
  parameter logic [31:0] SEED    = 32'hACE1_2468,
  localparam int unsigned SYM_W  = ($clog2(NUM_SYM) > 1) ? $clog2(NUM_SYM) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      seed_load,
  input  logic [31:0]               seed_in,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_samples,
  input  logic [NUM_SYM*PROB_W-1:0] probs,
  output logic                      busy,
  output logic                      done,
  output logic                      err_zero_sum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SYM_W-1:0]          out_sym,
  output logic [CNT_W-1:0]          out_idx
);

  localparam int unsigned SUM_W     = PROB_W + $clog2(NUM_SYM);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SUM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]                state;
  logic [31:0]               lfsr;
  logic [31:0]               lfsr_next;
  logic [NUM_SYM*PROB_W-1:0] probs_q;
  logic [CNT_W-1:0]          n_q;
  logic [CNT_W-1:0]          remaining;
  logic [SUM_W-1:0]          total_q;
  logic [NUM_SYM*SUM_W-1:0]  pre_q;
  logic [NUM_SYM*SUM_W-1:0]  pre_c;
  logic [SUM_W-1:0]          sum_acc;
  logic [SUM_W-1:0]          total_c;
  logic [16+SUM_W-1:0]       prod;
  logic [SUM_W-1:0]          r;
  logic [SYM_W-1:0]          sym_c;
  logic                      sym_found;
  logic                      load;

  always_comb begin
    sum_acc = '0;
    pre_c   = '0;
    for (int unsigned i = 0; i < NUM_SYM; i++) begin
      sum_acc = sum_acc + SUM_W'(probs_q[i*PROB_W +: PROB_W]);
      pre_c[i*SUM_W +: SUM_W] = sum_acc;
    end
    total_c = sum_acc;
  end

  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : '0);

  // r = (lfsr[31:16] * total) >> 16 always lies in 0..total-1
  assign prod = {{SUM_W{1'b0}}, lfsr[31:16]} * {16'd0, total_q};
  assign r    = SUM_W'(prod >> 16);

  // Lowest symbol whose prefix sum exceeds r; zero weights never win
  always_comb begin
    sym_c     = '0;
    sym_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SYM; i++) begin
      if (!sym_found && (r < pre_q[i*SUM_W +: SUM_W])) begin
        sym_c     = SYM_W'(i);
        sym_found = 1'b1;
      end
    end
  end

  assign load = (state == S_RUN) && (!out_valid || out_ready) && (remaining != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      lfsr         <= SEED;
      probs_q      <= '0;
      n_q          <= '0;
      remaining    <= '0;
      total_q      <= '0;
      pre_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_zero_sum <= 1'b0;
      out_valid    <= 1'b0;
      out_sym      <= '0;
      out_idx      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (seed_load) lfsr <= (seed_in == '0) ? SEED : seed_in;
          if (start) begin
            probs_q      <= probs;
            n_q          <= num_samples;
            err_zero_sum <= 1'b0;
            state        <= S_SUM;
          end
        end
        S_SUM: begin
          busy      <= 1'b1;
          total_q   <= total_c;
          pre_q     <= pre_c;
          remaining <= n_q;
          if (total_c == '0) begin
            err_zero_sum <= 1'b1;
            state        <= S_FIN;
          end else if (n_q == '0) begin
            state <= S_FIN;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (load) begin
            out_valid <= 1'b1;
            out_sym   <= sym_c;
            out_idx   <= n_q - remaining;
            remaining <= remaining - CNT_W'(1);
            lfsr      <= lfsr_next;
          end else if (out_valid && out_ready && (remaining == '0)) begin
            out_valid <= 1'b0;
            state     <= S_FIN;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rg_weighted_sampler.sv
// Directed bench for rg_weighted_sampler: a behavioural LFSR/categorical model
// predicts every sample; one negedge process compares the output streams.
module tb_rg_weighted_sampler;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load, start, ordy;
  logic [31:0] seed_in;
  logic [15:0] num4;
  logic [39:0] probs4;
  logic        busy4, done4, err4, ov4;
  logic [1:0]  osym4;
  logic [15:0] oidx4;

  logic         seed_load20, start20, ordy20;
  logic [31:0]  seed_in20;
  logic [15:0]  num20;
  logic [199:0] probs20;
  logic         busy20, done20, err20, ov20;
  logic [4:0]   osym20;
  logic [15:0]  oidx20;

  always #5 clk = ~clk;

  rg_weighted_sampler #(.NUM_SYM(4), .PROB_W(10), .CNT_W(16), .SEED(SEED)) dut4 (
    .clk(clk), .reset(rst_n), .seed_load(seed_load), .seed_in(seed_in), .start(start),
    .num_samples(num4), .probs(probs4), .busy(busy4), .done(done4), .err_zero_sum(err4),
    .out_valid(ov4), .out_ready(ordy), .out_sym(osym4), .out_idx(oidx4));

  rg_weighted_sampler #(.NUM_SYM(20), .PROB_W(10), .CNT_W(16), .SEED(SEED)) dut20 (
    .clk(clk), .reset(rst_n), .seed_load(seed_load20), .seed_in(seed_in20), .start(start20),
    .num_samples(num20), .probs(probs20), .busy(busy20), .done(done20), .err_zero_sum(err20),
    .out_valid(ov20), .out_ready(ordy20), .out_sym(osym20), .out_idx(oidx20));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_hs = 0;
  int hs_count = 0;
  int done4_cnt = 0;
  int done20_cnt = 0;
  int stall_seen = 0;
  int hist[4];
  int log4[$];
  int exp_sym4[$], exp_idx4[$], exp_sym20[$], exp_idx20[$];
  logic [31:0] model4, model20;

  logic [39:0] p_one  = {10'd0, 10'd0, 10'd1000, 10'd0};
  logic [39:0] p_uni  = {4{10'd250}};
  logic [39:0] p_zero = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic int pick(input logic [31:0] s, input int w[20], input int nsym);
    longint total = 0;
    longint r;
    longint cum = 0;
    for (int i = 0; i < nsym; i++) total += w[i];
    r = (longint'(s[31:16]) * total) >> 16;
    for (int i = 0; i < nsym; i++) begin
      cum += w[i];
      if (r < cum) return i;
    end
    return -1;
  endfunction

  // Single compare process for both DUTs
  always @(negedge clk) begin
    if (done4) done4_cnt++;
    if (done20) done20_cnt++;
    if (ov4) begin
      if (exp_sym4.size() == 0) check("unexpected_valid4", ov4, 0);
      else begin
        check("out_sym4", osym4, exp_sym4[0]);
        check("out_idx4", oidx4, exp_idx4[0]);
        if (ordy) begin
          hist[osym4]++;
          log4.push_back(int'(osym4));
          hs_count++;
          last_hs = cyc + 1;
          void'(exp_sym4.pop_front());
          void'(exp_idx4.pop_front());
        end
      end
    end
    if (ov20) begin
      if (exp_sym20.size() == 0) check("unexpected_valid20", ov20, 0);
      else begin
        check("out_sym20", osym20, exp_sym20[0]);
        check("out_idx20", oidx20, exp_idx20[0]);
        if (ordy20) begin
          void'(exp_sym20.pop_front());
          void'(exp_idx20.pop_front());
        end
      end
    end
  end

  task automatic start4(input logic [39:0] p, input int n, input bit ld, input logic [31:0] sd,
                        output int k, output int tot);
    int w[20];
    tot = 0;
    for (int i = 0; i < 20; i++) w[i] = 0;
    for (int i = 0; i < 4; i++) begin
      w[i] = int'(p[i*10 +: 10]);
      tot += w[i];
    end
    if (ld) model4 = (sd == 0) ? SEED : sd;
    if (tot > 0)
      for (int j = 0; j < n; j++) begin
        exp_sym4.push_back(pick(model4, w, 4));
        exp_idx4.push_back(j);
        model4 = lfsr_step(model4);
      end
    probs4 = p; num4 = 16'(n); seed_load = ld; seed_in = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; seed_load = 1'b0;
    k = cyc;
    check("err_cleared_on_start", err4, 0);
  endtask

  task automatic run4(input logic [39:0] p, input int n, input bit ld, input logic [31:0] sd,
                      input int stall_idx, input int stall_len);
    int k, tot, sc, dcyc;
    bit got;
    start4(p, n, ld, sd, k, tot);
    sc = 0; got = 0; dcyc = 0;
    for (int c = 0; c < n + stall_len + 20 && !got; c++) begin
      @(posedge clk); #1;
      if (cyc == k + 1) begin
        check("busy_at_k1", busy4, 1);
        check("no_valid_at_k1", ov4, 0);
      end
      if (cyc == k + 2 && tot > 0 && n > 0) check("first_valid_at_k2", ov4, 1);
      if (ov4 && int'(oidx4) == stall_idx && sc < stall_len) begin
        ordy = 1'b0;
        sc++;
      end else ordy = 1'b1;
      if (done4) begin
        got = 1;
        dcyc = cyc;
      end
    end
    stall_seen = sc;
    check("done_seen", got, 1);
    if (got) begin
      if (tot == 0) check("done_latency_zero_sum", dcyc - k, 2);
      else check("done_after_last_handshake", dcyc - last_hs, 1);
      check("busy_low_at_done", busy4, 0);
      check("err_zero_sum", err4, tot == 0);
      check("no_lost_samples", exp_sym4.size(), 0);
      @(posedge clk); #1;
      check("done_one_cycle", done4, 0);
    end
  endtask

  initial begin
    int runA[$];
    int k, tot, h0, d0;
    bit got;
    int w20[20];

    rst_n = 1'b0; seed_load = 0; start = 0; seed_in = '0; num4 = '0; probs4 = '0; ordy = 1'b1;
    seed_load20 = 0; start20 = 0; seed_in20 = '0; num20 = '0; probs20 = '0; ordy20 = 1'b1;
    model4 = SEED; model20 = SEED;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs4", {busy4, done4, err4, ov4, osym4, oidx4}, 0);
    check("reset_outs20", {busy20, done20, err20, ov20, osym20, oidx20}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Only symbol 1 has weight; then the same with a 3-cycle stall at sample 2
    run4(p_one, 5, 0, 0, -1, 0);
    run4(p_one, 5, 0, 0, 2, 3);
    check("stall_cycles", stall_seen, 3);
    // Exactly 10 advances so far: a uniform batch exposes any drift
    run4(p_uni, 8, 0, 0, -1, 0);

    // Zero total weight
    run4(p_zero, 10, 0, 0, -1, 0);
    repeat (2) @(posedge clk);
    #1;
    check("err_sticky", err4, 1);

    // Seed load and start together, 4000 uniform samples
    log4.delete();
    for (int i = 0; i < 4; i++) hist[i] = 0;
    run4(p_uni, 4000, 1, 32'h1, -1, 0);
    check("pin_s0", log4[0], 0);
    check("pin_s1", log4[1], 2);
    check("pin_s2", log4[2], 3);
    check("pin_s3", log4[3], 1);
    check("pin_s4", log4[4], 2);
    for (int s = 0; s < 4; s++) check("hist_within_10pct", (hist[s] >= 900 && hist[s] <= 1100), 1);

    // Determinism across reseeds
    log4.delete();
    run4(p_uni, 8, 1, 32'h1234_5678, -1, 0);
    runA = log4;
    log4.delete();
    run4(p_uni, 8, 1, 32'h1234_5678, -1, 0);
    check("repeat_len", log4.size(), 8);
    for (int i = 0; i < 8; i++) check("repeat_seq", log4[i], runA[i]);

    // Reset mid-batch after the third sample
    h0 = hs_count;
    start4(p_uni, 8, 0, 0, k, tot);
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(posedge clk); #1;
      if (hs_count >= h0 + 3) got = 1;
    end
    check("three_samples_before_reset", got, 1);
    d0 = done4_cnt;
    rst_n = 1'b0;
    exp_sym4.delete(); exp_idx4.delete();
    model4 = SEED;
    #1;
    check("reset_midbatch_outs", {busy4, done4, err4, ov4, osym4, oidx4}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_done_after_abort", done4_cnt - d0, 0);
    check("idle_after_abort", {busy4, ov4}, 0);
    run4(p_uni, 8, 0, 0, -1, 0);

    // 20-symbol instance, weight only on symbol 19, start pulsed mid-batch
    for (int i = 0; i < 20; i++) w20[i] = 0;
    w20[19] = 1000;
    for (int j = 0; j < 6; j++) begin
      exp_sym20.push_back(pick(model20, w20, 20));
      exp_idx20.push_back(j);
      model20 = lfsr_step(model20);
    end
    check("model_pick19", exp_sym20[0], 19);
    probs20 = '0;
    probs20[190 +: 10] = 10'd1000;
    num20 = 16'd6;
    start20 = 1'b1;
    d0 = done20_cnt;
    @(posedge clk); #1;
    start20 = 1'b0;
    k = cyc;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      if (cyc == k + 3 || cyc == k + 5) begin
        start20 = 1'b1;
        num20 = 16'd9;
      end else start20 = 1'b0;
      if (done20) got = 1;
    end
    start20 = 1'b0;
    check("done20_seen", got, 1);
    check("no_lost_samples20", exp_sym20.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    check("single_done20", done20_cnt - d0, 1);
    check("idle20", {busy20, ov20}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
